// File: rtl/pipe_stage.sv
// pipe_stage: parametrised valid/ready pipeline register with flush and stall.
// Define PIPE_SKID_EN to compile in a one-entry skid buffer with registered ready.
module pipe_stage #(
    parameter int unsigned       DATA_W          = 145,
    parameter logic [DATA_W-1:0] NOP_VAL         = '0,
    parameter logic [DATA_W-1:0] FLUSH_KEEP_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              stall
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              main_valid;
    logic              in_xfer;
    logic              out_xfer;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              skid_valid;

    assign skid_valid = (state_q == ST_SKID);
`endif

    assign main_valid = (state_q != ST_EMPTY);
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;
    assign out_data   = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (!stall) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_xfer && !in_xfer) begin
                        state_d = ST_EMPTY;
                    end
`ifdef PIPE_SKID_EN
                    if (in_xfer && !out_xfer) begin
                        state_d = ST_SKID;
                    end
`endif
                end
`ifdef PIPE_SKID_EN
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d = ST_FULL;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Flush forces ready so an offered beat is swallowed, not left pending.
    always_comb begin
        out_valid = main_valid & ~stall & ~flush;
`ifdef PIPE_SKID_EN
        in_ready  = (~skid_valid & ~stall) | flush;
`else
        in_ready  = (~stall & (~main_valid | out_ready)) | flush;
`endif
    end

    always_comb begin
        data_d = data_q;
`ifdef PIPE_SKID_EN
        skid_d = skid_q;
`endif
        if (flush) begin
            data_d = (data_q & FLUSH_KEEP_MASK)
                   | (NOP_VAL & ~FLUSH_KEEP_MASK);
        end else if (!stall) begin
`ifdef PIPE_SKID_EN
            if (skid_valid) begin
                if (out_xfer) begin
                    data_d = skid_q;
                end
            end else if (in_xfer) begin
                if (main_valid && !out_xfer) begin
                    skid_d = in_data;
                end else begin
                    data_d = in_data;
                end
            end
`else
            if (in_xfer) begin
                data_d = in_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= NOP_VAL;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q <= NOP_VAL;
        end else begin
            skid_q <= skid_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the stage.
module tb_pipe_stage;

    localparam int W = 32;
    localparam logic [W-1:0] NOP  = 32'h0000_0013;
    localparam logic [W-1:0] KEEP = 32'hFFFF_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         flush = 1'b0;
    logic         stall = 1'b0;

    pipe_stage #(
        .DATA_W(W),
        .NOP_VAL(NOP),
        .FLUSH_KEEP_MASK(KEEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .flush(flush),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: resident beats in order, plus the payload shown when empty.
    logic [W-1:0] mq[$];
    logic [W-1:0] held = '0;
    bit           known = 1'b0;
    logic [W-1:0] outs[$];

    logic         obs_ir;
    logic         obs_ov;
    logic [W-1:0] obs_od;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         st;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_od;
    } vec_t;

    vec_t vecs[13];

    function automatic void chk(input string nm, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act,
                                 input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endfunction

    task automatic step(input logic r, input logic iv, input logic [W-1:0] d,
                        input logic ordy, input logic fl, input logic st);
        int           n;
        logic [W-1:0] cur;
        logic         e_ir;
        logic         e_ov;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        stall     = st;
        #1;
        obs_ir = in_ready;
        obs_ov = out_valid;
        obs_od = out_data;
        n    = mq.size();
        cur  = (n > 0) ? mq[0] : held;
        e_ov = (n > 0) && !st && !fl;
`ifdef PIPE_SKID_EN
        e_ir = fl || (!st && n < 2);
`else
        e_ir = fl || (!st && (n == 0 || ordy));
`endif
        if (known) begin
            chk1("model in_ready", obs_ir, e_ir);
            chk1("model out_valid", obs_ov, e_ov);
            chk("model out_data", obs_od, cur);
            if (!r && obs_ov && ordy) outs.push_back(obs_od);
        end
        if (r) begin
            mq.delete();
            held  = NOP;
            known = 1'b1;
        end else if (fl) begin
            mq.delete();
            held = (cur & KEEP) | (NOP & ~KEEP);
        end else if (!st) begin
            if (e_ov && ordy) void'(mq.pop_front());
            if (iv && e_ir) mq.push_back(d);
            held = (mq.size() > 0) ? mq[0] : cur;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        outs.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic         accepted;
        logic         r, iv, ordy, fl, st;
        logic [W-1:0] d;

        for (int i = 0; i < 8; i++) begin
            vecs[i].iv   = 1'b1;
            vecs[i].d    = W'(i + 1);
            vecs[i].ordy = 1'b1;
            vecs[i].fl   = 1'b0;
            vecs[i].st   = 1'b0;
            vecs[i].e_ir = 1'b1;
            vecs[i].e_ov = (i > 0);
            vecs[i].e_od = (i == 0) ? NOP : W'(i);
        end
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8};
        vecs[11] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b0, 32'h8};
        vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                     (32'h8 & KEEP) | (NOP & ~KEEP)};

        // Reset state
        do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk1("reset in_ready", obs_ir, 1'b1);
        chk1("reset out_valid", obs_ov, 1'b0);
        chk("reset out_data", obs_od, NOP);

        // Streaming table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(1'b0, vecs[i].iv, vecs[i].d, vecs[i].ordy,
                 vecs[i].fl, vecs[i].st);
            chk1($sformatf("vec%0d in_ready", i), obs_ir, vecs[i].e_ir);
            chk1($sformatf("vec%0d out_valid", i), obs_ov, vecs[i].e_ov);
            chk($sformatf("vec%0d out_data", i), obs_od, vecs[i].e_od);
        end

        // Backpressure with a full stage
        do_reset();
        step(1'b0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
        accepted = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, !accepted, 32'hBB, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
            chk1($sformatf("bp%0d in_ready", k), obs_ir, k == 0);
`else
            chk1($sformatf("bp%0d in_ready", k), obs_ir, 1'b0);
`endif
            chk("bp hold data", obs_od, 32'hAA);
            if (obs_ir && !accepted) accepted = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, !accepted, 32'hBB, 1'b1, 1'b0, 1'b0);
            if (obs_ir && !accepted) accepted = 1'b1;
        end
        chk("bp beat count", 32'(outs.size()), 32'd2);
        if (outs.size() == 2) begin
            chk("bp beat0", outs[0], 32'hAA);
            chk("bp beat1", outs[1], 32'hBB);
        end

        // Flush alone, then flush together with stall
        for (int s = 0; s < 2; s++) begin
            do_reset();
            step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b1, s == 1);
            chk1("flush in_ready", obs_ir, 1'b1);
            chk1("flush out_valid", obs_ov, 1'b0);
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk1("post flush out_valid", obs_ov, 1'b0);
            chk("post flush data", obs_od,
                (32'h1234_5678 & KEEP) | (NOP & ~KEEP));
            idle(3);
            chk("flush beats out", 32'(outs.size()), 32'd0);
        end

        // Stall holds a full stage
        do_reset();
        step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
            chk1("stall in_ready", obs_ir, 1'b0);
            chk1("stall out_valid", obs_ov, 1'b0);
            chk("stall data", obs_od, 32'h55);
        end
        idle(3);
        chk("stall beat count", 32'(outs.size()), 32'd1);
        if (outs.size() == 1) chk("stall beat", outs[0], 32'h55);

        // Reset with two beats offered under backpressure
        do_reset();
        step(1'b0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hBB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        outs.delete();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk1("rst mid in_ready", obs_ir, 1'b1);
        chk1("rst mid out_valid", obs_ov, 1'b0);
        chk("rst mid data", obs_od, NOP);
        idle(3);
        chk("rst mid beats", 32'(outs.size()), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r    = ($urandom_range(0, 249) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            d    = $urandom;
            ordy = ($urandom_range(0, 4) > 1);
            fl   = ($urandom_range(0, 39) == 0);
            st   = ($urandom_range(0, 9) == 0);
            step(r, iv, d, ordy, fl, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
